// File: rtl/exm_lane_sync.sv
// exm_lane_sync: joins the results of LANES parallel execute lanes into a
// single in-order commit bundle for WB.
//   - A lane that finishes before its group can leave has its result held in
//     a per-lane capture register and reports lane_captured so the lane does
//     not restart its multi-cycle unit.
//   - The group fires when every valid lane is done (live or captured) and
//     the one-entry WB output register is free. The bundle is visible on
//     out_* one cycle later.
//   - flush drops any captured results and any pending output bundle.
//   - stall_cnt is a saturating count of cycles a group was present but did
//     not fire. Only reset clears it.
// Ports:
//   clk, reset (sync, active-high), flush
//   in_valid/lane_done/lane_result/lane_dest/lane_we : per-lane execute side
//   lane_captured, group_ready                        : back to lanes / ID
//   out_valid/out_ready/out_lane_valid/out_result/out_dest/out_we : WB side
//   stall_cnt                                         : stall statistics

// Per-lane capture slot: EXEC (cap=0) / HELD (cap=1).
module exm_lane_sync_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              fire,
  input  logic              in_valid_i,
  input  logic              lane_done_i,
  input  logic [DATA_W-1:0] lane_result_i,
  output logic              cap_o,
  output logic              ok_o,
  output logic [DATA_W-1:0] eff_o
);
  logic              cap_q;
  logic [DATA_W-1:0] hold_q;
  logic              capture;

  // Capture only when the result would otherwise be lost. A lane finishing
  // in the fire cycle goes straight to the output instead.
  assign capture = in_valid_i & lane_done_i & ~cap_q & ~fire & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q  <= 1'b0;
      hold_q <= '0;
    end else if (flush | fire) begin
      cap_q  <= 1'b0;
    end else if (capture) begin
      cap_q  <= 1'b1;
      hold_q <= lane_result_i;
    end
  end

  assign cap_o = cap_q;
  assign ok_o  = ~in_valid_i | lane_done_i | cap_q;
  assign eff_o = cap_q ? hold_q : lane_result_i;
endmodule

module exm_lane_sync #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES-1:0]               lane_done,
  input  logic [LANES-1:0][DATA_W-1:0]   lane_result,
  input  logic [LANES-1:0][DEST_W-1:0]   lane_dest,
  input  logic [LANES-1:0]               lane_we,
  output logic [LANES-1:0]               lane_captured,
  output logic                           group_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0]               out_lane_valid,
  output logic [LANES-1:0][DATA_W-1:0]   out_result,
  output logic [LANES-1:0][DEST_W-1:0]   out_dest,
  output logic [LANES-1:0]               out_we,
  output logic [CNT_W-1:0]               stall_cnt
);
  logic [LANES-1:0]             cap;
  logic [LANES-1:0]             lane_ok;
  logic [LANES-1:0][DATA_W-1:0] eff;
  logic present, all_ok, slot_free, fire;

  logic                         out_valid_q;
  logic [LANES-1:0]             out_lane_valid_q;
  logic [LANES-1:0][DATA_W-1:0] out_result_q;
  logic [LANES-1:0][DEST_W-1:0] out_dest_q;
  logic [LANES-1:0]             out_we_q;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  assign present   = |in_valid;
  assign all_ok    = &lane_ok;
  assign slot_free = ~out_valid_q | out_ready;
  assign fire      = present & all_ok & slot_free & ~flush;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exm_lane_sync_lane #(.DATA_W(DATA_W)) u_lane (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .fire          (fire),
      .in_valid_i    (in_valid[g]),
      .lane_done_i   (lane_done[g]),
      .lane_result_i (lane_result[g]),
      .cap_o         (cap[g]),
      .ok_o          (lane_ok[g]),
      .eff_o         (eff[g])
    );
  end

  // One-entry WB register. Flush kills the pending bundle even while WB is
  // back-pressuring; result/dest need no clearing since valid gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_lane_valid_q <= '0;
      out_result_q     <= '0;
      out_dest_q       <= '0;
      out_we_q         <= '0;
    end else if (flush) begin
      out_valid_q      <= 1'b0;
      out_lane_valid_q <= '0;
      out_we_q         <= '0;
    end else if (slot_free) begin
      if (fire) begin
        out_valid_q      <= 1'b1;
        out_lane_valid_q <= in_valid;
        out_result_q     <= eff;
        out_dest_q       <= lane_dest;
        out_we_q         <= lane_we & in_valid;
      end else begin
        out_valid_q      <= 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (present && !fire && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  // Combinational on purpose: ID sees the consume in the same cycle.
  assign group_ready    = fire | ~present;
  assign lane_captured  = cap;
  assign out_valid      = out_valid_q;
  assign out_lane_valid = out_lane_valid_q;
  assign out_result     = out_result_q;
  assign out_dest       = out_dest_q;
  assign out_we         = out_we_q;
  assign stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_exm_lane_sync.sv
module tb_exm_lane_sync;
  localparam int LANES = 2, DATA_W = 32, DEST_W = 5, CNT_W = 16;

  logic                         clk = 1'b0;
  logic                         reset, flush;
  logic [LANES-1:0]             in_valid, lane_done, lane_we;
  logic [LANES-1:0][DATA_W-1:0] lane_result;
  logic [LANES-1:0][DEST_W-1:0] lane_dest;
  logic [LANES-1:0]             lane_captured;
  logic                         group_ready, out_valid, out_ready;
  logic [LANES-1:0]             out_lane_valid, out_we;
  logic [LANES-1:0][DATA_W-1:0] out_result;
  logic [LANES-1:0][DEST_W-1:0] out_dest;
  logic [CNT_W-1:0]             stall_cnt;

  typedef struct {
    logic [LANES-1:0]             lv;
    logic [LANES-1:0][DATA_W-1:0] res;
    logic [LANES-1:0][DEST_W-1:0] dst;
    logic [LANES-1:0]             we;
  } bundle_t;

  bundle_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exm_lane_sync #(.LANES(LANES), .DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .lane_done(lane_done), .lane_result(lane_result), .lane_dest(lane_dest),
    .lane_we(lane_we), .lane_captured(lane_captured), .group_ready(group_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_result(out_result), .out_dest(out_dest), .out_we(out_we),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] iv, input logic [1:0] dn,
                       input logic [31:0] r1, input logic [31:0] r0,
                       input logic [4:0] d1, input logic [4:0] d0, input logic [1:0] we);
    in_valid = iv; lane_done = dn;
    lane_result[1] = r1; lane_result[0] = r0;
    lane_dest[1] = d1;   lane_dest[0] = d0;
    lane_we = we;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00);
  endtask

  // Expected bundle, built from the values the bench itself chose.
  task automatic push_exp(input logic [1:0] iv, input logic [31:0] r1, input logic [31:0] r0,
                          input logic [4:0] d1, input logic [4:0] d0, input logic [1:0] we);
    bundle_t b;
    b.lv = iv; b.res[1] = r1; b.res[0] = r0;
    b.dst[1] = d1; b.dst[0] = d0; b.we = we & iv;
    sb.push_back(b);
  endtask

  // Monitor: every accepted bundle is checked against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: got bundle res=%0h with empty queue", out_result);
      end else begin
        bundle_t e;
        logic [LANES-1:0][DATA_W-1:0] ar, er;
        logic [LANES-1:0][DEST_W-1:0] ad, ed;
        e = sb.pop_front();
        ar = '0; er = '0; ad = '0; ed = '0;
        for (int i = 0; i < LANES; i++) if (e.lv[i]) begin
          ar[i] = out_result[i]; er[i] = e.res[i];
          ad[i] = out_dest[i];   ed[i] = e.dst[i];
        end
        chk("sb_lane_valid", 64'(out_lane_valid), 64'(e.lv));
        chk("sb_we",         64'(out_we),         64'(e.we));
        chk("sb_result",     64'(ar),             64'(er));
        chk("sb_dest",       64'(ad),             64'(ed));
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    smp();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_captured",  64'(lane_captured), 64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    chk("rst_out_we",    64'(out_we), 64'd0);

    // Both lanes done at once: fires immediately, visible next cycle.
    cyc(); reset = 1'b0;
    drive(2'b11, 2'b11, 32'h22, 32'h11, 5'd2, 5'd1, 2'b11);
    push_exp(2'b11, 32'h22, 32'h11, 5'd2, 5'd1, 2'b11);
    smp(); chk("t1_group_ready", 64'(group_ready), 64'd1);
    chk("t1_out_valid_pre", 64'(out_valid), 64'd0);
    cyc(); idle();
    smp(); chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_stall", 64'(stall_cnt), 64'd0);

    // Lane0 early, its live result changes; lane1 finishes three cycles later.
    cyc(); drive(2'b11, 2'b01, 32'h99, 32'hAAAA0000, 5'd4, 5'd3, 2'b11);
    smp(); chk("t2_gr_c0", 64'(group_ready), 64'd0);
    chk("t2_cap_c0", 64'(lane_captured), 64'd0);
    for (int c = 1; c <= 2; c++) begin
      cyc(); drive(2'b11, 2'b00, 32'h99, 32'hDEAD, 5'd4, 5'd3, 2'b11);
      smp(); chk("t2_cap_wait", 64'(lane_captured), 64'b01);
    end
    cyc(); drive(2'b11, 2'b10, 32'h5, 32'hDEAD, 5'd4, 5'd3, 2'b11);
    push_exp(2'b11, 32'h5, 32'hAAAA0000, 5'd4, 5'd3, 2'b11);
    smp(); chk("t2_cap_c3", 64'(lane_captured), 64'b01);
    chk("t2_gr_c3", 64'(group_ready), 64'd1);
    chk("t2_stall", 64'(stall_cnt), 64'd3);
    cyc(); idle();
    smp(); chk("t2_cap_clear", 64'(lane_captured), 64'd0);

    // Output stalled by WB while the next group completes.
    cyc(); drive(2'b11, 2'b11, 32'h0B, 32'h0A, 5'd6, 5'd5, 2'b11);
    push_exp(2'b11, 32'h0B, 32'h0A, 5'd6, 5'd5, 2'b11);
    cyc(); out_ready = 1'b0;
    drive(2'b11, 2'b11, 32'h44, 32'h33, 5'd8, 5'd7, 2'b01);
    smp(); chk("t3_gr_blocked", 64'(group_ready), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      cyc(); drive(2'b11, 2'b00, 32'hBAD, 32'hBAD, 5'd8, 5'd7, 2'b01);
      smp(); chk("t3_cap", 64'(lane_captured), 64'b11);
      chk("t3_out_hold", 64'(out_valid), 64'd1);
    end
    cyc(); out_ready = 1'b1;
    push_exp(2'b11, 32'h44, 32'h33, 5'd8, 5'd7, 2'b01);
    smp(); chk("t3_gr_fire", 64'(group_ready), 64'd1);
    cyc(); idle();
    smp(); chk("t3_stall", 64'(stall_cnt), 64'd7);
    chk("t3_cap_clear", 64'(lane_captured), 64'd0);

    // Partial group: lane0 not valid, its we must be masked.
    cyc(); drive(2'b10, 2'b10, 32'h7, 32'h123, 5'd3, 5'd9, 2'b11);
    push_exp(2'b10, 32'h7, 32'h123, 5'd3, 5'd9, 2'b11);
    smp(); chk("t4_gr", 64'(group_ready), 64'd1);
    cyc(); idle();
    smp(); chk("t4_out_we", 64'(out_we), 64'b10);

    // Back-to-back groups at full throughput.
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(2'b11, 2'b11, 32'h100 + 32'(k), 32'h200 + 32'(k), 5'(k), 5'(k + 10), 2'b11);
      push_exp(2'b11, 32'h100 + 32'(k), 32'h200 + 32'(k), 5'(k), 5'(k + 10), 2'b11);
      smp(); chk("t5_b2b_gr", 64'(group_ready), 64'd1);
    end
    cyc(); idle();
    smp(); chk("t5_b2b_valid", 64'(out_valid), 64'd1);
    cyc();
    smp(); chk("t5_drained", 64'(out_valid), 64'd0);

    // Flush with a captured lane and a stuck output bundle (never accepted).
    cyc(); out_ready = 1'b0;
    drive(2'b11, 2'b11, 32'hC1, 32'hC0, 5'd1, 5'd1, 2'b11);
    cyc(); drive(2'b11, 2'b01, 32'h0, 32'h50, 5'd2, 5'd2, 2'b11);
    smp(); chk("t6_out_stuck", 64'(out_valid), 64'd1);
    cyc(); flush = 1'b1;
    drive(2'b11, 2'b10, 32'h60, 32'h0, 5'd2, 5'd2, 2'b11);
    smp(); chk("t6_cap_pre", 64'(lane_captured), 64'b01);
    chk("t6_gr_flush", 64'(group_ready), 64'd0);
    cyc(); flush = 1'b0; out_ready = 1'b1; idle();
    smp(); chk("t6_cap_flushed", 64'(lane_captured), 64'd0);
    chk("t6_out_flushed", 64'(out_valid), 64'd0);
    chk("t6_stall", 64'(stall_cnt), 64'd8);
    cyc(); drive(2'b11, 2'b11, 32'hE1, 32'hE0, 5'd12, 5'd11, 2'b10);
    push_exp(2'b11, 32'hE1, 32'hE0, 5'd12, 5'd11, 2'b10);
    cyc(); idle();
    smp(); chk("t6_next_valid", 64'(out_valid), 64'd1);

    // Long stall: counter saturates, reset clears counter and capture.
    cyc(); drive(2'b11, 2'b01, 32'h0, 32'h77, 5'd0, 5'd0, 2'b11);
    cyc(); drive(2'b11, 2'b00, 32'h0, 32'h77, 5'd0, 5'd0, 2'b11);
    smp(); chk("t7_cap", 64'(lane_captured), 64'b01);
    repeat (70000) cyc();
    smp(); chk("t7_sat", 64'(stall_cnt), 64'hFFFF);
    chk("t7_cap_held", 64'(lane_captured), 64'b01);
    cyc(); reset = 1'b1;
    cyc();
    smp(); chk("t7_rst_stall", 64'(stall_cnt), 64'd0);
    chk("t7_rst_cap", 64'(lane_captured), 64'd0);
    chk("t7_rst_valid", 64'(out_valid), 64'd0);
    cyc(); reset = 1'b0; idle();
    smp();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exm_lane_sync.md
Name: exm_lane_sync

Overview:
- Parametrised successor to the dual-issue execute-stage pairing logic: joins results from LANES parallel execute lanes into one in-order commit bundle for the WB stage.
- A lane that finishes early has its result captured and held. The bundle is released only when every valid lane is done and the WB output register is free.
- Sits between the per-lane EXM datapaths (ALU/mul/div/dcache) and WB.
- Also drives a per-lane "captured" indication so a finished lane suppresses re-issue to its multi-cycle unit, and counts group stall cycles.

Parameters:
- LANES, 2, number of issue lanes (1..8).
- DATA_W, 32, result width per lane.
- DEST_W, 5, register destination index width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush (branch mispredict / exception). Synchronous; highest priority after reset.
- in_valid  in  LANES  lane i holds an instruction in the current group.
- lane_done  in  LANES  lane i result available this cycle (level; may drop after capture).
- lane_result  in  LANES*DATA_W  lane i result, bits [i*DATA_W +: DATA_W].
- lane_dest  in  LANES*DEST_W  lane i destination register.
- lane_we  in  LANES  lane i writes the register file.
- lane_captured  out  LANES  lane i result is held internally; lane must not restart its unit.
- group_ready  out  1  current group consumed this cycle (to ID, as stage ready).
- out_valid  out  1  WB bundle valid.
- out_ready  in  1  WB accepts the bundle.
- out_lane_valid  out  LANES  per-lane valid inside the bundle.
- out_result  out  LANES*DATA_W  bundle results.
- out_dest  out  LANES*DEST_W  bundle destinations.
- out_we  out  LANES  bundle write enables; forced 0 where out_lane_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles the group was present but did not fire.

Behaviour:
- Definitions:
  - present = |in_valid.
  - lane_ok[i] = ~in_valid[i] | lane_done[i] | cap[i].
  - all_ok = &lane_ok.
  - slot_free = ~out_valid | out_ready.
  - fire = present & all_ok & slot_free & ~flush.
- Per-lane state, 2 states:
  - EXEC (cap=0) -> HELD (cap=1) when in_valid[i] & lane_done[i] & ~fire & ~flush. On this transition hold_r[i] <= lane_result[i].
  - HELD -> EXEC on fire or flush.
  - HELD ignores further lane_done / lane_result changes.
- Effective lane value: eff[i] = cap[i] ? hold_r[i] : lane_result[i]. dest and we are taken live from the inputs; they are stable while the group is held.
- Output register, updated only when slot_free:
  - On fire: out_valid <= 1, out_lane_valid <= in_valid, out_result <= eff, out_dest <= lane_dest, out_we <= lane_we & in_valid.
  - When slot_free & ~fire: out_valid <= 0.
  - When ~slot_free: all out_* hold.
- Latency: a group whose lanes are all done in cycle N appears on out_valid in cycle N+1 (1-cycle registered).
- group_ready = fire | ~present. It is combinational and must not depend on lane_captured.
- lane_captured = cap, registered.
- Stall counter:
  - stall_cnt += 1 each cycle with present & ~fire & ~flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Flush:
  - Clears all cap bits and out_valid / out_lane_valid / out_we in the same edge.
  - Overrides fire and capture.
  - stall_cnt holds.
- Reset: all cap=0, hold_r=0, out_valid=0, out_lane_valid=0, out_result=0, out_dest=0, out_we=0, stall_cnt=0.
- Boundary cases:
  - present=0: no fire, no capture; output drains if out_ready.
  - All lanes done while the output is stalled: each done lane captures; fire happens the first cycle out_ready=1. Values come from hold_r even if lane_result has since changed.
  - Lane done and fire in the same cycle: no capture; the result goes straight to the output.
  - LANES=1 degenerates to a 1-deep registered skid with a capture hold.
  - Simultaneous fire and out_ready: back-to-back bundles at full throughput, no bubble.

Test Plan:
- Reset, then in_valid=2'b11 and lane_done=2'b11 with results 0x11 / 0x22, out_ready=1 -> next cycle out_valid=1, out_result={0x22,0x11}; group_ready=1 in the issue cycle; stall_cnt=0.
- Lane0 done in cycle 0 with 0xAAAA0000, then its result changes to 0xDEAD; lane1 done in cycle 3 with 0x5 -> lane_captured=2'b01 in cycles 1–3; fire in cycle 3; bundle lane0=0xAAAA0000; stall_cnt=3.
- Both lanes done, out_ready=0 held for 4 cycles -> out_valid stays at the previous bundle; cap=2'b11; fire on the first out_ready=1 with the captured values; stall_cnt increases by 4.
- in_valid=2'b10 only, lane1 done with 0x7 and lane_we=1 -> out_lane_valid=2'b10, out_we=2'b10; lane0 ignored.
- Lane0 captured, then flush asserted with lane1 done -> no fire; cap=0 and out_valid=0 next cycle; the following group fires normally.
- Hold present with no done for 70000 cycles at CNT_W=16 -> stall_cnt saturates at 0xFFFF; a reset mid-hold returns it to 0 and clears cap.
